// File: rtl/texture_load_controller_if.sv
// Command, rasterizer-handshake, AXI-stream and status signals of the texture load controller.
interface texture_load_controller_if #(
  parameter int unsigned STREAM_WIDTH = 16
);
  logic                    cmdValid;
  logic                    cmdReady;
  logic [3:0]              cmdMode;
  logic                    rasterizerIdle;
  logic                    rasterizerStall;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [STREAM_WIDTH-1:0] s_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;
  logic [STREAM_WIDTH-1:0] m_axis_tdata;
  logic [3:0]              texMode;
  logic                    loadDone;
  logic                    loadError;

  // Controller side
  modport slave (
    input  cmdValid, cmdMode, rasterizerIdle,
    input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
    output cmdReady, rasterizerStall, s_axis_tready,
    output m_axis_tvalid, m_axis_tlast, m_axis_tdata,
    output texMode, loadDone, loadError
  );

  // Command parser / stream source / texture buffer side
  modport master (
    output cmdValid, cmdMode, rasterizerIdle,
    output s_axis_tvalid, s_axis_tlast, s_axis_tdata, m_axis_tready,
    input  cmdReady, rasterizerStall, s_axis_tready,
    input  m_axis_tvalid, m_axis_tlast, m_axis_tdata,
    input  texMode, loadDone, loadError
  );
endinterface

// File: rtl/texture_load_controller.sv
// Texture load controller: accepts a load command, stalls the rasterizer until it
// drains, forwards exactly one texture of beats into the texture buffer, and
// publishes the new texture mode only after a complete upload.
module texture_load_controller #(
  parameter int unsigned STREAM_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  texture_load_controller_if.slave  bus
);

  localparam int unsigned PIXEL_WIDTH = 16;
  localparam int unsigned CNT_W       = 15;
  localparam int unsigned BEATS_32    = (1024  * PIXEL_WIDTH) / STREAM_WIDTH;
  localparam int unsigned BEATS_64    = (4096  * PIXEL_WIDTH) / STREAM_WIDTH;
  localparam int unsigned BEATS_128   = (16384 * PIXEL_WIDTH) / STREAM_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_IDLE, STREAM, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              pending_mode_q;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic [3:0]              tex_mode_q;
  logic                    load_done_q;
  logic                    load_error_q;
  logic                    stall_q;

  logic                    mode_legal_c;
  logic [CNT_W-1:0]        last_idx_c;
  logic                    last_beat_c;
  logic                    hs_c;
  logic                    cmd_ready_c;
  logic                    s_tready_c;
  logic                    m_tvalid_c;
  logic                    m_tlast_c;
  logic [STREAM_WIDTH-1:0] m_tdata_c;

  // Mode legality and index of the final beat for the pending texture size
  always_comb begin
    mode_legal_c = (bus.cmdMode == 4'b0001) || (bus.cmdMode == 4'b0010) ||
                   (bus.cmdMode == 4'b0100);
    case (pending_mode_q)
      4'b0010: last_idx_c = CNT_W'(BEATS_64 - 1);
      4'b0100: last_idx_c = CNT_W'(BEATS_128 - 1);
      default: last_idx_c = CNT_W'(BEATS_32 - 1);
    endcase
    last_beat_c = (beat_cnt_q == last_idx_c);
    hs_c        = (state_q == STREAM) && bus.s_axis_tvalid && bus.m_axis_tready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and stream passthrough
  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    s_tready_c  = 1'b0;
    m_tvalid_c  = 1'b0;
    m_tlast_c   = 1'b0;
    m_tdata_c   = '0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmdValid && mode_legal_c) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (bus.rasterizerIdle) state_d = STREAM;
      end
      STREAM: begin
        m_tvalid_c = bus.s_axis_tvalid;
        s_tready_c = bus.m_axis_tready;
        m_tdata_c  = bus.s_axis_tdata;
        m_tlast_c  = last_beat_c || bus.s_axis_tlast;
        if (hs_c && (last_beat_c || bus.s_axis_tlast)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending mode, beat counter, published mode and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_mode_q <= '0;
      beat_cnt_q     <= '0;
      tex_mode_q     <= '0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      stall_q     <= (state_d == WAIT_IDLE) || (state_d == STREAM);
      load_done_q <= (state_d == DONE);
      if (state_q != STREAM) beat_cnt_q <= '0;
      if ((state_q == IDLE) && bus.cmdValid) begin
        pending_mode_q <= bus.cmdMode;
        load_error_q   <= !mode_legal_c;
      end
      if (hs_c) begin
        if (last_beat_c) begin
          tex_mode_q <= pending_mode_q;
        end else if (bus.s_axis_tlast) begin
          // Short upload: mark the texture invalid
          tex_mode_q   <= '0;
          load_error_q <= 1'b1;
        end else begin
          beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.cmdReady        = cmd_ready_c;
  assign bus.rasterizerStall = stall_q;
  assign bus.s_axis_tready   = s_tready_c;
  assign bus.m_axis_tvalid   = m_tvalid_c;
  assign bus.m_axis_tlast    = m_tlast_c;
  assign bus.m_axis_tdata    = m_tdata_c;
  assign bus.texMode         = tex_mode_q;
  assign bus.loadDone        = load_done_q;
  assign bus.loadError       = load_error_q;

endmodule
